symbol_mapper: RTL



---
 rtl/symbol_mapper.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/symbol_mapper.sv
// rtl/symbol_mapper.sv - FIFO byte consumer mapping bytes to I/Q symbols at a programmable rate (optional scrambler: SYMBOL_MAPPER_SCRAMBLE_EN)
module symbol_mapper #(
    parameter int DIV_W = 16,
    parameter int AMP   = 127
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             baud_wr,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_q,
    output logic             fifo_rd,
    output logic [7:0]       i_mul,
    output logic [7:0]       q_mul,
    output logic             sym_stb,
    output logic             underflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE
    } state_t;

    localparam logic [1:0] MODE_BPSK  = 2'd0;
    localparam logic [1:0] MODE_QPSK  = 2'd1;
    localparam logic [1:0] MODE_QAM16 = 2'd2;

    // Full-scale and 16QAM levels; the inner level is AMP/3 truncated.
    localparam int         LVL    = AMP / 3;
    localparam logic [7:0] AMP_P  = 8'(AMP);
    localparam logic [7:0] AMP_N  = 8'(-AMP);
    localparam logic [7:0] L1_P   = 8'(LVL);
    localparam logic [7:0] L1_N   = 8'(-LVL);
    localparam logic [7:0] L3_P   = 8'(3 * LVL);
    localparam logic [7:0] L3_N   = 8'(-3 * LVL);

`ifdef SYMBOL_MAPPER_SCRAMBLE_EN
    localparam logic [6:0] SCR_SEED = 7'h7F;
`endif

    // Gray-coded 16QAM amplitude for one bit pair.
    function automatic logic [7:0] qam_level(input logic [1:0] b);
        logic [7:0] v;
        case (b)
            2'b00:   v = L3_N;
            2'b01:   v = L1_N;
            2'b11:   v = L1_P;
            default: v = L3_P;
        endcase
        return v;
    endfunction

    // Maps the leading bits of an MSB-aligned word to {I, Q}.
    function automatic logic [15:0] map_symbol(input logic [1:0] m, input logic [7:0] bits);
        logic [7:0] i_v;
        logic [7:0] q_v;
        i_v = 8'h00;
        q_v = 8'h00;
        case (m)
            MODE_BPSK: begin
                i_v = bits[7] ? AMP_P : AMP_N;
            end
            MODE_QPSK: begin
                i_v = bits[7] ? AMP_P : AMP_N;
                q_v = bits[6] ? AMP_P : AMP_N;
            end
            MODE_QAM16: begin
                i_v = qam_level(bits[7:6]);
                q_v = qam_level(bits[5:4]);
            end
            default: begin
                i_v = bits;
            end
        endcase
        return {i_v, q_v};
    endfunction

    // Drops the bits consumed by one symbol, keeping the remainder MSB-aligned.
    function automatic logic [7:0] shift_bits(input logic [1:0] m, input logic [7:0] bits);
        logic [7:0] r;
        case (m)
            MODE_BPSK:  r = {bits[6:0], 1'b0};
            MODE_QPSK:  r = {bits[5:0], 2'b00};
            MODE_QAM16: r = {bits[3:0], 4'h0};
            default:    r = 8'h00;
        endcase
        return r;
    endfunction

    // Symbols remaining after the first one of a freshly loaded byte.
    function automatic logic [2:0] syms_after_first(input logic [1:0] m);
        logic [2:0] r;
        case (m)
            MODE_BPSK:  r = 3'd7;
            MODE_QPSK:  r = 3'd3;
            MODE_QAM16: r = 3'd1;
            default:    r = 3'd0;
        endcase
        return r;
    endfunction

`ifdef SYMBOL_MAPPER_SCRAMBLE_EN
    // Additive scrambler over one byte, MSB first; returns {next state, scrambled byte}.
    function automatic logic [14:0] scramble(input logic [6:0] s_in, input logic [7:0] d);
        logic [6:0] s;
        logic [7:0] o;
        logic       f;
        s = s_in;
        o = 8'h00;
        for (int k = 7; k >= 0; k--) begin
            f    = s[6] ^ s[3];
            o[k] = d[k] ^ f;
            s    = {s[5:0], f};
        end
        return {s, o};
    endfunction
`endif

    state_t           state_q, state_d;
    logic             fifo_rd_q, fifo_rd_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       count_q, count_d;
    logic [1:0]       mode_q, mode_d;
    logic [7:0]       i_q, i_d;
    logic [7:0]       q_q, q_d;
    logic             sym_stb_q, sym_stb_d;
    logic             underflow_q, underflow_d;
`ifdef SYMBOL_MAPPER_SCRAMBLE_EN
    logic [6:0]       scr_q, scr_d;
    logic             en_q, en_d;
`endif

    logic             tick;
    logic             capture;
    logic [7:0]       src_byte;
    logic [15:0]      sym_iq;

    // Symbol-rate divider: a write restarts the count and suppresses that cycle's tick.
    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        tick  = en && !baud_wr && (cnt_q == div_q);
        if (baud_wr) begin
            div_d = baud_div;
        end
        if (!en || baud_wr || (cnt_q == div_q)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Prefetch FSM: one outstanding read, captured into the holding byte.
    always_comb begin
        state_d   = state_q;
        fifo_rd_d = 1'b0;
        capture   = (state_q == ST_CAPTURE);
        case (state_q)
            ST_IDLE: begin
                if (en && !hold_valid_q && !fifo_empty) begin
                    state_d   = ST_READ;
                    fifo_rd_d = 1'b1;
                end
            end
            ST_READ:  state_d = ST_CAPTURE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Symbol engine: shift out the current byte, load the next one, or flag underflow.
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shreg_d      = shreg_q;
        count_d      = count_q;
        mode_d       = mode_q;
        i_d          = i_q;
        q_d          = q_q;
        sym_stb_d    = 1'b0;
        underflow_d  = 1'b0;
        sym_iq       = 16'h0000;
        src_byte     = hold_valid_q ? hold_q : fifo_q;
`ifdef SYMBOL_MAPPER_SCRAMBLE_EN
        en_d  = en;
        scr_d = scr_q;
        if (en_q && !en) begin
            scr_d = SCR_SEED;
        end
`endif

        if (capture) begin
            hold_d       = fifo_q;
            hold_valid_d = 1'b1;
        end

        if (!en) begin
            shreg_d = 8'h00;
            count_d = 3'd0;
            i_d     = 8'h00;
            q_d     = 8'h00;
        end else if (tick) begin
            if (count_q != 3'd0) begin
                sym_iq    = map_symbol(mode_q, shreg_q);
                shreg_d   = shift_bits(mode_q, shreg_q);
                count_d   = count_q - 1'b1;
                i_d       = sym_iq[15:8];
                q_d       = sym_iq[7:0];
                sym_stb_d = 1'b1;
            end else if (hold_valid_q || capture) begin
`ifdef SYMBOL_MAPPER_SCRAMBLE_EN
                {scr_d, src_byte} = scramble(scr_q, src_byte);
`endif
                sym_iq       = map_symbol(mode, src_byte);
                shreg_d      = shift_bits(mode, src_byte);
                count_d      = syms_after_first(mode);
                mode_d       = mode;
                hold_valid_d = 1'b0;
                i_d          = sym_iq[15:8];
                q_d          = sym_iq[7:0];
                sym_stb_d    = 1'b1;
            end else begin
                i_d         = 8'h00;
                q_d         = 8'h00;
                underflow_d = 1'b1;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fifo_rd_q    <= 1'b0;
            div_q        <= '0;
            cnt_q        <= '0;
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
            shreg_q      <= 8'h00;
            count_q      <= 3'd0;
            mode_q       <= 2'd0;
            i_q          <= 8'h00;
            q_q          <= 8'h00;
            sym_stb_q    <= 1'b0;
            underflow_q  <= 1'b0;
`ifdef SYMBOL_MAPPER_SCRAMBLE_EN
            scr_q        <= SCR_SEED;
            en_q         <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            fifo_rd_q    <= fifo_rd_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shreg_q      <= shreg_d;
            count_q      <= count_d;
            mode_q       <= mode_d;
            i_q          <= i_d;
            q_q          <= q_d;
            sym_stb_q    <= sym_stb_d;
            underflow_q  <= underflow_d;
`ifdef SYMBOL_MAPPER_SCRAMBLE_EN
            scr_q        <= scr_d;
            en_q         <= en_d;
`endif
        end
    end

    assign fifo_rd   = fifo_rd_q;
    assign i_mul     = i_q;
    assign q_mul     = q_q;
    assign sym_stb   = sym_stb_q;
    assign underflow = underflow_q;
    assign busy      = hold_valid_q | (count_q != 3'd0) | (state_q != ST_IDLE);

endmodule
